// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared widths and result types for the write-back port arbiter
package wb_port_arbiter_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned TRANS_ID_BITS = 4;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_select.sv
// rtl/wb_rr_select.sv - round-robin picker: valid vector plus pointer to one-hot grant
module wb_rr_select #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] rr_ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic [PW:0] cand;
  logic        found;

  // Scan from rr_ptr upward with wrap; rr_ptr < N keeps the sum below 2*N.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr_i} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) begin
        cand = cand - (PW+1)'(N);
      end
      if (!found && valid_i[cand[PW-1:0]]) begin
        found                  = 1'b1;
        grant_o[cand[PW-1:0]]  = 1'b1;
        idx_o                  = cand[PW-1:0];
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - per-FU result buffers sharing one scoreboard write-back port
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [NR_REQ-1:0]        req_valid_i,
  output logic [NR_REQ-1:0]        req_ready_o,
  input  logic [TRANS_ID_BITS-1:0] req_trans_id_i [NR_REQ],
  input  logic [XLEN-1:0]          req_data_i     [NR_REQ],
  input  exception_t               req_ex_i       [NR_REQ],
  output logic                     wt_valid_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic [XLEN-1:0]          wbdata_o,
  output exception_t               ex_o,
  output logic [NR_REQ-1:0]        grant_o
);

  localparam int unsigned PW = idx_width(NR_REQ);

  logic [NR_REQ-1:0]        buf_valid_q, buf_valid_d;
  logic [TRANS_ID_BITS-1:0] buf_id_q   [NR_REQ];
  logic [XLEN-1:0]          buf_data_q [NR_REQ];
  exception_t               buf_ex_q   [NR_REQ];
  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;

  logic [NR_REQ-1:0] pick_valid;
  logic [NR_REQ-1:0] grant;
  logic [NR_REQ-1:0] accept;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_any;

  // Flush hides every buffer from the picker, so grant and write-back vanish together.
  assign pick_valid = flush_i ? '0 : buf_valid_q;

  wb_rr_select #(
    .N  (NR_REQ),
    .PW (PW)
  ) u_rr_select (
    .valid_i  (pick_valid),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (grant),
    .idx_o    (gnt_idx),
    .any_o    (gnt_any)
  );

  assign req_ready_o = {NR_REQ{!flush_i}} & (~buf_valid_q | grant);
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    buf_valid_d = buf_valid_q;
    for (int i = 0; i < NR_REQ; i++) begin
      if (flush_i) begin
        buf_valid_d[i] = 1'b0;
      end else if (accept[i]) begin
        buf_valid_d[i] = 1'b1;
      end else if (grant[i]) begin
        buf_valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == PW'(NR_REQ - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_valid_q <= '0;
      rr_ptr_q    <= '0;
      for (int i = 0; i < NR_REQ; i++) begin
        buf_id_q[i]   <= '0;
        buf_data_q[i] <= '0;
        buf_ex_q[i]   <= '0;
      end
    end else begin
      buf_valid_q <= buf_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      for (int i = 0; i < NR_REQ; i++) begin
        if (accept[i]) begin
          buf_id_q[i]   <= req_trans_id_i[i];
          buf_data_q[i] <= req_data_i[i];
          buf_ex_q[i]   <= req_ex_i[i];
        end
      end
    end
  end

  always_comb begin
    wt_valid_o = gnt_any;
    grant_o    = grant;
    trans_id_o = '0;
    wbdata_o   = '0;
    ex_o       = '0;
    if (gnt_any) begin
      trans_id_o = buf_id_q[gnt_idx];
      wbdata_o   = buf_data_q[gnt_idx];
      ex_o       = buf_ex_q[gnt_idx];
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int N = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush;
  logic [N-1:0]             rv;
  logic [N-1:0]             rdy;
  logic [TRANS_ID_BITS-1:0] tid [N];
  logic [XLEN-1:0]          dat [N];
  exception_t               exi [N];
  logic                     wt;
  logic [TRANS_ID_BITS-1:0] tid_o;
  logic [XLEN-1:0]          wbd;
  exception_t               ex_o;
  logic [N-1:0]             gnt;

  wb_port_arbiter #(.NR_REQ(N)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .req_valid_i    (rv),
    .req_ready_o    (rdy),
    .req_trans_id_i (tid),
    .req_data_i     (dat),
    .req_ex_i       (exi),
    .wt_valid_o     (wt),
    .trans_id_o     (tid_o),
    .wbdata_o       (wbd),
    .ex_o           (ex_o),
    .grant_o        (gnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] v;
    int         i0, i1, i2;
    logic       fl;
    logic       ewt;
    int         eid;
    logic [2:0] eg;
    logic [2:0] erdy;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] v, input int a, input int b, input int c,
                              input logic fl, input logic ewt, input int eid,
                              input logic [2:0] eg, input logic [2:0] erdy);
    vec_t r;
    r.v = v; r.i0 = a; r.i1 = b; r.i2 = c; r.fl = fl;
    r.ewt = ewt; r.eid = eid; r.eg = eg; r.erdy = erdy;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] dpat(input int id);
    return 32'hD000_0000 | XLEN'(id);
  endfunction

  task automatic clear_inputs();
    rv = '0;
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      tid[i] = '0;
      dat[i] = '0;
      exi[i] = '0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_wt"}, 64'(wt), 64'd0);
    chk({tag, "_grant"}, 64'(gnt), 64'd0);
    chk({tag, "_id"}, 64'(tid_o), 64'd0);
    chk({tag, "_data"}, 64'(wbd), 64'd0);
    chk({tag, "_exv"}, 64'(ex_o.valid), 64'd0);
    chk({tag, "_excause"}, 64'(ex_o.cause), 64'd0);
  endtask

  // Reference model state: one slot per FU plus the round-robin pointer.
  logic                     mv   [N];
  logic [TRANS_ID_BITS-1:0] mid  [N];
  logic [XLEN-1:0]          mdat [N];
  exception_t               mex  [N];
  int                       macc [N];
  int                       mrr;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0; mid[i] = '0; mdat[i] = '0; mex[i] = '0; macc[i] = 0;
    end
    mrr = 0;
  endtask

  vec_t tbl[$];

  initial begin
    int cyc;
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_ready", 64'(rdy), 64'b111);
    @(negedge clk);
    rst_n = 1'b1;

    // v, fu0/fu1/fu2 ids, flush -> wt, id, grant, ready
    tbl.push_back(mk(3'b111, 5, 6, 7, 0, 0, 0, 3'b000, 3'b111));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 1, 5, 3'b001, 3'b001));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 1, 6, 3'b010, 3'b011));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 1, 7, 3'b100, 3'b111));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b111));
    tbl.push_back(mk(3'b001, 1, 0, 0, 0, 0, 0, 3'b000, 3'b111));
    tbl.push_back(mk(3'b001, 2, 0, 0, 0, 1, 1, 3'b001, 3'b111));
    tbl.push_back(mk(3'b001, 3, 0, 0, 0, 1, 2, 3'b001, 3'b111));
    tbl.push_back(mk(3'b001, 4, 0, 0, 0, 1, 3, 3'b001, 3'b111));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 1, 4, 3'b001, 3'b111));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b111));
    tbl.push_back(mk(3'b101, 1, 0, 2, 0, 0, 0, 3'b000, 3'b111));
    tbl.push_back(mk(3'b101, 3, 0, 4, 0, 1, 2, 3'b100, 3'b110));
    tbl.push_back(mk(3'b101, 5, 0, 6, 0, 1, 1, 3'b001, 3'b011));
    tbl.push_back(mk(3'b101, 7, 0, 8, 0, 1, 4, 3'b100, 3'b110));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 1, 5, 3'b001, 3'b011));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 1, 8, 3'b100, 3'b111));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b111));
    tbl.push_back(mk(3'b011, 1, 2, 0, 0, 0, 0, 3'b000, 3'b111));
    tbl.push_back(mk(3'b000, 0, 0, 0, 1, 0, 0, 3'b000, 3'b000));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b111));

    for (int r = 0; r < tbl.size(); r++) begin
      rv     = tbl[r].v;
      flush  = tbl[r].fl;
      tid[0] = TRANS_ID_BITS'(tbl[r].i0); dat[0] = dpat(tbl[r].i0);
      tid[1] = TRANS_ID_BITS'(tbl[r].i1); dat[1] = dpat(tbl[r].i1);
      tid[2] = TRANS_ID_BITS'(tbl[r].i2); dat[2] = dpat(tbl[r].i2);
      #2;
      chk($sformatf("tbl%0d_wt", r), 64'(wt), 64'(tbl[r].ewt));
      chk($sformatf("tbl%0d_id", r), 64'(tid_o), 64'(tbl[r].eid));
      chk($sformatf("tbl%0d_grant", r), 64'(gnt), 64'(tbl[r].eg));
      chk($sformatf("tbl%0d_ready", r), 64'(rdy), 64'(tbl[r].erdy));
      chk($sformatf("tbl%0d_data", r), 64'(wbd), tbl[r].ewt ? 64'(dpat(tbl[r].eid)) : 64'd0);
      chk($sformatf("tbl%0d_exv", r), 64'(ex_o.valid), 64'd0);
      @(negedge clk);
    end

    // Reset mid-operation: move rr_ptr off zero, then load an excepting entry into buffer 2.
    clear_inputs();
    rv = 3'b010; tid[1] = 4'd9; dat[1] = dpat(9);
    @(negedge clk);
    rv = 3'b100; tid[2] = 4'd3; dat[2] = dpat(3);
    exi[2].valid = 1'b1; exi[2].cause = 32'h0000_000B;
    #2;
    chk("rst_pre_wt", 64'(wt), 64'd1);
    chk("rst_pre_id", 64'(tid_o), 64'd9);
    chk("rst_pre_grant", 64'(gnt), 64'b010);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("rst_buf2_grant", 64'(gnt), 64'b100);
    chk("rst_buf2_exv", 64'(ex_o.valid), 64'd1);
    chk("rst_buf2_excause", 64'(ex_o.cause), 64'h0B);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    chk("rst_mid_ready", 64'(rdy), 64'b111);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle_outputs("rst_after");
    chk("rst_after_ready", 64'(rdy), 64'b111);
    rv = 3'b111;
    for (int i = 0; i < N; i++) begin
      tid[i] = TRANS_ID_BITS'(10 + i);
      dat[i] = dpat(10 + i);
    end
    @(negedge clk);
    clear_inputs();
    for (int k = 0; k < N; k++) begin
      #1;
      chk($sformatf("rst_rr_grant%0d", k), 64'(gnt), 64'(3'b001 << k));
      chk($sformatf("rst_rr_id%0d", k), 64'(tid_o), 64'(10 + k));
      @(negedge clk);
    end

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
    for (int t = 0; t < 400; t++) begin
      int g;
      logic [N-1:0] erdy;
      rv    = N'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) begin
        tid[i]       = TRANS_ID_BITS'($urandom);
        dat[i]       = $urandom;
        exi[i].valid = $urandom_range(0, 3) == 0;
        exi[i].cause = $urandom;
        exi[i].tval  = $urandom;
      end
      #2;
      g = -1;
      if (!flush) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (mrr + k) % N;
          if (g < 0 && mv[j]) g = j;
        end
      end
      for (int i = 0; i < N; i++) erdy[i] = !flush && (!mv[i] || g == i);
      chk("rnd_wt", 64'(wt), 64'(g >= 0));
      chk("rnd_grant", 64'(gnt), (g >= 0) ? 64'(1 << g) : 64'd0);
      chk("rnd_ready", 64'(rdy), 64'(erdy));
      if (g >= 0) begin
        chk("rnd_id", 64'(tid_o), 64'(mid[g]));
        chk("rnd_data", 64'(wbd), 64'(mdat[g]));
        chk("rnd_exv", 64'(ex_o.valid), 64'(mex[g].valid));
        chk("rnd_excause", 64'(ex_o.cause), 64'(mex[g].cause));
        chk("rnd_latency", 64'((cyc - macc[g]) <= N), 64'd1);
      end else begin
        chk("rnd_idle_id", 64'(tid_o), 64'd0);
        chk("rnd_idle_exv", 64'(ex_o.valid), 64'd0);
      end
      @(posedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (flush) begin
          mv[i] = 1'b0;
        end else if (rv[i] && erdy[i]) begin
          mv[i] = 1'b1; mid[i] = tid[i]; mdat[i] = dat[i]; mex[i] = exi[i]; macc[i] = cyc;
        end else if (g == i) begin
          mv[i] = 1'b0;
        end
      end
      if (g >= 0) mrr = (g + 1) % N;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter NR_REQ, default 3, number of functional units sharing one scoreboard write-back port (range 2..8).
REQ-002 SHALL have port clk_i, input, 1, clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port flush_i, input, 1, pipeline flush; discards all buffered results.
REQ-005 SHALL have port req_valid_i, input, NR_REQ, per-FU result valid.
REQ-006 SHALL have port req_ready_o, output, NR_REQ, per-FU result accepted this cycle when high together with req_valid_i.
REQ-007 SHALL have port req_trans_id_i, input, NR_REQ x TRANS_ID_BITS, per-FU scoreboard transaction id.
REQ-008 SHALL have port req_data_i, input, NR_REQ x riscv::XLEN, per-FU result data.
REQ-009 SHALL have port req_ex_i, input, NR_REQ x exception_t, per-FU exception.
REQ-010 SHALL have port wt_valid_o, output, 1, write-back valid to scoreboard.
REQ-011 SHALL have port trans_id_o, output, TRANS_ID_BITS, write-back transaction id.
REQ-012 SHALL have port wbdata_o, output, riscv::XLEN, write-back data.
REQ-013 SHALL have port ex_o, output, exception_t, write-back exception.
REQ-014 SHALL have port grant_o, output, NR_REQ, one-hot index of the buffer written back this cycle (all-zero when idle).

Function
REQ-015 SHALL hold one single-entry buffer per requester (valid bit, trans_id, data, exception).
REQ-016 SHALL drive req_ready_o[i] = !flush_i && (!buf_valid[i] || grant_o[i]).
REQ-017 SHALL capture req_*_i[i] into buffer i on the cycle req_valid_i[i] && req_ready_o[i].
REQ-018 SHALL present write-back combinationally from buffers only: accept in cycle N gives earliest wt_valid_o in cycle N+1; no input-to-output bypass.
REQ-019 SHALL select among valid buffers by round-robin: highest priority at rr_ptr, then ascending index modulo NR_REQ.
REQ-020 SHALL, on a grant to index g, update rr_ptr to (g+1) mod NR_REQ; rr_ptr unchanged when idle.
REQ-021 SHALL assert wt_valid_o iff any buffer valid and !flush_i; the scoreboard port never backpressures, so the granted buffer is freed the same cycle.
REQ-022 SHALL, when wt_valid_o is low, drive trans_id_o, wbdata_o, ex_o (incl. ex_o.valid) and grant_o to zero.
REQ-023 SHALL allow, in the same cycle, drain of buffer i and refill of buffer i (back-to-back throughput of 1 per cycle for a lone requester).
REQ-024 SHALL, on flush_i, clear all buffer valid bits, suppress wt_valid_o and all req_ready_o that cycle; rr_ptr keeps its value.
REQ-025 SHALL guarantee an accepted result is written back within NR_REQ cycles of acceptance (no starvation).
REQ-026 SHALL never write back the same buffered entry twice nor drop an accepted entry absent flush.

Reset
REQ-027 SHALL, while rst_ni low, clear all buffer valid bits, set rr_ptr to 0, and drive wt_valid_o=0, grant_o=0, trans_id_o=0, wbdata_o=0, ex_o=0, req_ready_o=all-ones once rst_ni and flush_i permit.
REQ-028 SHALL discard any in-flight entry on reset assertion mid-operation; first accept is possible in the first clock edge after deassertion.

Structure
REQ-029 SHALL take exception_t, TRANS_ID_BITS and riscv::XLEN from the existing shared packages; no new package typedefs needed.
REQ-030 SHALL place the round-robin picker (valid vector + rr_ptr -> one-hot grant) in one sub-module, wb_rr_select.
REQ-031 SHALL be instantiable in front of one write-back port of the issue stage without changes to the scoreboard.

Verification
REQ-032 Single FU: req_valid_i=3'b001 for 4 cycles, ids 1..4 -> wt_valid_o cycles N+1..N+4, trans_id_o 1,2,3,4, ready held high.
REQ-033 All three FUs valid same cycle, rr_ptr=0, ids 5/6/7 -> write-backs 5,6,7 on consecutive cycles, grant_o 001,010,100, rr_ptr ends 0.
REQ-034 Continuous contention FU0 and FU2 -> grants alternate 001,100,001,...; each accepted entry written back within 3 cycles.
REQ-035 Flush with buffers 0 and 1 full -> same cycle wt_valid_o=0, req_ready_o=000; next cycle buffers empty, no stale write-back.
REQ-036 rst_ni low for 1 cycle while buffer 2 full with ex_o.valid=1 -> wt_valid_o=0, all outputs zero, rr_ptr=0 after release.
REQ-037 Idle cycle -> trans_id_o=0, wbdata_o=0, ex_o.valid=0, grant_o=000.
